// File: rtl/hwpe_stream_sink_linear_if.sv
// TCDM write-port and HWPE stream bundles
// used by the linear stream sink.
interface hwpe_stream_intf_tcdm ();
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;

  modport master (
    output req, add, wen, be, data,
    input  gnt
  );
  modport slave (
    input  req, add, wen, be, data,
    output gnt
  );
endinterface

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );
  modport sink (
    input  valid, data, strb,
    output ready
  );
endinterface

// File: rtl/hwpe_stream_sink_linear.sv
// Stream-to-TCDM linear writer with per-beat lane fencing.
// Define HWPE_STREAM_SINK_STRB_EN to forward stream strobes as byte enables.
module hwpe_stream_sink_linear #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH/32,
  parameter int unsigned TRANS_CNT     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 clear_i,
  hwpe_stream_intf_tcdm.master tcdm [NB_TCDM_PORTS-1:0],
  hwpe_stream_intf_stream.sink stream,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [TRANS_CNT-1:0] trans_size_i,
  output logic                 ready_start_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WORKING = 1'b1;

  logic [0:0]               state_q;
  logic [31:0]              base_q;
  logic [TRANS_CNT-1:0]     trans_q;
  logic [TRANS_CNT-1:0]     beat_cnt;
  logic [NB_TCDM_PORTS-1:0] fence_hs;
  logic [NB_TCDM_PORTS-1:0] gnt;
  logic [NB_TCDM_PORTS-1:0] lgnt;
  logic                     done_q;
  logic                     working;
  logic                     hs;
  logic                     last;
  logic [31:0]              beat_off;

  assign working  = state_q == WORKING;
  assign lgnt     = gnt | fence_hs;
  assign hs       = stream.valid & stream.ready;
  assign last     = beat_cnt == trans_q - TRANS_CNT'(1);
  assign beat_off = 32'(beat_cnt) * (NB_TCDM_PORTS*4);

  assign stream.ready  = working & (&lgnt);
  assign ready_start_o = ~working;
  assign busy_o        = working;
  assign done_o        = done_q;

  for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : g_lane
    logic [31:0] lane_add;
    assign lane_add     = base_q + beat_off + 32'(i*4);
    assign gnt[i]       = tcdm[i].gnt;
    assign tcdm[i].req  = working & stream.valid & ~fence_hs[i];
    assign tcdm[i].wen  = 1'b0;
    assign tcdm[i].add  = working ? lane_add : '0;
    assign tcdm[i].data = working ? stream.data[32*i+:32] : '0;
`ifdef HWPE_STREAM_SINK_STRB_EN
    assign tcdm[i].be   = working ? stream.strb[4*i+:4] : '0;
`else
    assign tcdm[i].be   = working ? 4'hF : 4'h0;
`endif
  end

`ifdef HWPE_STREAM_SINK_STRB_EN
  logic unused_inputs;
  assign unused_inputs = test_mode_i;
`else
  logic unused_inputs;
  assign unused_inputs = ^{test_mode_i, stream.strb};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_q   <= '0;
      trans_q  <= '0;
      beat_cnt <= '0;
      fence_hs <= '0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      beat_cnt <= '0;
      fence_hs <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q   <= base_addr_i;
            trans_q  <= trans_size_i;
            beat_cnt <= '0;
            fence_hs <= '0;
            if (trans_size_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= WORKING;
            end
          end
        end
        WORKING: begin
          if (hs) begin
            fence_hs <= '0;
            if (last) begin
              state_q  <= IDLE;
              beat_cnt <= '0;
              done_q   <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + TRANS_CNT'(1);
            end
          end else if (stream.valid) begin
            // remember lanes already written so they are not re-issued
            fence_hs <= fence_hs | gnt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_sink_linear.sv
// Scoreboard bench for hwpe_stream_sink_linear
// with two TCDM ports and a queue-based reference model.
module tb_hwpe_stream_sink_linear;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_i = '0;
  logic [15:0] size_i = '0;
  logic        rdy_start, busy, done;

  logic [1:0]  req_v;
  logic [1:0]  gnt_v = 2'b00;
  logic [31:0] add_v [2];
  logic [31:0] data_v [2];
  logic [3:0]  be_v [2];
  bit          gnt_rand = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  wr_t q0[$];
  wr_t q1[$];
  logic [63:0] bdata [16];
  logic [7:0]  bstrb [16];

  int cur_size = 0;
  int beats = 0;
  bit done_exp = 1'b0;

  hwpe_stream_intf_tcdm tcdm [1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(64)) strm ();

  for (genvar g = 0; g < 2; g++) begin : g_tc
    assign req_v[g]    = tcdm[g].req;
    assign add_v[g]    = tcdm[g].add;
    assign data_v[g]   = tcdm[g].data;
    assign be_v[g]     = tcdm[g].be;
    assign tcdm[g].gnt = gnt_v[g];
  end

  hwpe_stream_sink_linear #(
    .DATA_WIDTH(64)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_mode_i  (1'b0),
    .clear_i      (clear),
    .tcdm         (tcdm),
    .stream       (strm),
    .start_i      (start),
    .base_addr_i  (base_i),
    .trans_size_i (size_i),
    .ready_start_o(rdy_start),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [3:0] exp_be(logic [7:0] s, int p);
`ifdef HWPE_STREAM_SINK_STRB_EN
    return (p == 0) ? s[3:0] : s[7:4];
`else
    if (s == 8'h00 && p < 0) return 4'h0;
    return 4'hF;
`endif
  endfunction

  always @(posedge clk) begin
    #2;
    if (gnt_rand) gnt_v = 2'($urandom);
  end

  // monitor: pop expected writes, track beats to predict done
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (req_v[p] && gnt_v[p]) begin
          wr_t e;
          bit ok;
          ok = 1'b0;
          if (p == 0 && q0.size() > 0) begin
            e = q0.pop_front(); ok = 1'b1;
          end else if (p == 1 && q1.size() > 0) begin
            e = q1.pop_front(); ok = 1'b1;
          end
          if (ok) begin
            check($sformatf("add_p%0d", p), add_v[p], e.a);
            check($sformatf("data_p%0d", p), data_v[p], e.d);
            check($sformatf("be_p%0d", p), 32'(be_v[p]), 32'(e.be));
          end else begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_write port=%0d actual=%h required=none",
                     p, add_v[p]);
          end
        end
      end
      if (done || done_exp) check("done", 32'(done), 32'(done_exp));
      done_exp = 1'b0;
      if (clear) begin
        beats = 0;
      end else if (start) begin
        beats = 0;
        cur_size = int'(size_i);
        if (cur_size == 0) done_exp = 1'b1;
      end else if (strm.valid && strm.ready) begin
        beats++;
        if (beats == cur_size) done_exp = 1'b1;
      end
    end
  end

  task automatic prep(input logic [31:0] base, input int size,
                      input bit rnd_strb);
    for (int b = 0; b < size; b++) begin
      bdata[b] = {$urandom, $urandom};
      bstrb[b] = rnd_strb ? 8'($urandom) : 8'hF0;
      for (int p = 0; p < 2; p++) begin
        wr_t e;
        e.a  = base + 32'(8*b + 4*p);
        e.d  = (p == 0) ? bdata[b][31:0] : bdata[b][63:32];
        e.be = exp_be(bstrb[b], p);
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic do_start(input logic [31:0] base, input int size);
    base_i = base;
    size_i = 16'(size);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit rnd, output int cyc);
    int b;
    bit pres;
    bit hs;
    b = 0;
    pres = 1'b0;
    cyc = 0;
    while (b < n && cyc < 500) begin
      if (!pres) begin
        if (!rnd || $urandom_range(0, 3) != 0) begin
          strm.valid = 1'b1;
          strm.data  = bdata[b];
          strm.strb  = bstrb[b];
          pres = 1'b1;
        end else begin
          strm.valid = 1'b0;
        end
      end
      @(negedge clk);
      hs = strm.valid && strm.ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        b++;
        pres = 1'b0;
      end
    end
    strm.valid = 1'b0;
    check("beats_sent", b, n);
  endtask

  task automatic xfer(input logic [31:0] base, input int size,
                      input bit rnd, output int cyc);
    prep(base, size, rnd);
    do_start(base, size);
    send_beats(size, rnd, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    strm.valid = 1'b0;
    strm.data  = '0;
    strm.strb  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(req_v), 0);
    check("rst_add", add_v[0] | add_v[1], 0);
    check("rst_data", data_v[0] | data_v[1], 0);
    check("rst_be", 32'(be_v[0] | be_v[1]), 0);
    check("rst_ready", 32'(strm.ready), 0);
    check("rst_ready_start", 32'(rdy_start), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full-rate transfer
    gnt_v = 2'b11;
    xfer(32'h1000, 4, 1'b0, cyc);
    check("consecutive_beats", cyc, 4);

    // partial grant on beat 1
    prep(32'h3000, 2, 1'b0);
    do_start(32'h3000, 2);
    strm.valid = 1'b1;
    strm.data = bdata[0];
    strm.strb = bstrb[0];
    @(negedge clk);
    check("fence_b0_ready", 32'(strm.ready), 1);
    @(posedge clk); #1;
    strm.data = bdata[1];
    strm.strb = bstrb[1];
    gnt_v = 2'b01;
    @(negedge clk);
    check("fence_req0", 32'(req_v), 32'h3);
    check("fence_ready0", 32'(strm.ready), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("fence_req_held", 32'(req_v), 32'h2);
      check("fence_ready_held", 32'(strm.ready), 0);
    end
    @(posedge clk); #1;
    gnt_v = 2'b10;
    @(negedge clk);
    check("fence_req_last", 32'(req_v), 32'h2);
    check("fence_ready_last", 32'(strm.ready), 1);
    @(posedge clk); #1;
    strm.valid = 1'b0;
    gnt_v = 2'b11;
    @(posedge clk); #1;

    // zero-size start
    strm.valid = 1'b1;
    do_start(32'h5000, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("size0_req", 32'(req_v), 0);
      check("size0_ready_start", 32'(rdy_start), 1);
      if (k == 0) check("size0_done", 32'(done), 1);
      @(posedge clk); #1;
    end
    strm.valid = 1'b0;

    // clear mid-transfer, then restart
    prep(32'h4000, 8, 1'b0);
    do_start(32'h4000, 8);
    send_beats(3, 1'b0, cyc);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("clr_busy", 32'(busy), 0);
    check("clr_ready_start", 32'(rdy_start), 1);
    check("clr_done", 32'(done), 0);
    @(posedge clk); #1;
    xfer(32'h2000, 2, 1'b0, cyc);

    // address wrap
    xfer(32'hFFFF_FFF8, 3, 1'b0, cyc);

    // random back-to-back transfers
    gnt_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      logic [31:0] b;
      b = $urandom & 32'hFFFF_FFFC;
      xfer(b, int'($urandom_range(1, 9)), 1'b1, cyc);
    end
    gnt_rand = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
